// File: rtl/lsu_pkg.sv
// lsu_pkg: shared definitions for the load/store read-modify-write unit.
//   - req_size encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_RSVD)
//   - FSM state enum (IDLE, ACCESS, WRITE, RESP)
package lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WRITE  = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational big-endian lane handling.
// Extract path:
//   ext_word, ext_off, ext_size, ext_signed -> ext_data (lane, extended to 32 bits)
// Merge path:
//   mrg_old, mrg_new, mrg_off, mrg_size -> mrg_data (old word with one lane replaced
//   by the low byte/halfword of mrg_new; the whole of mrg_new for word size)
// Offset 0 is the most significant byte/halfword.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] ext_word,
  input  logic [1:0]  ext_off,
  input  logic [1:0]  ext_size,
  input  logic        ext_signed,
  output logic [31:0] ext_data,
  input  logic [31:0] mrg_old,
  input  logic [31:0] mrg_new,
  input  logic [1:0]  mrg_off,
  input  logic [1:0]  mrg_size,
  output logic [31:0] mrg_data
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  // Select the addressed lane and extend it to the full word.
  always_comb begin
    lane8    = ext_word[31:24];
    lane16   = ext_off[1] ? ext_word[15:0] : ext_word[31:16];
    ext_data = ext_word;
    case (ext_off)
      2'd0:    lane8 = ext_word[31:24];
      2'd1:    lane8 = ext_word[23:16];
      2'd2:    lane8 = ext_word[15:8];
      2'd3:    lane8 = ext_word[7:0];
      default: lane8 = ext_word[31:24];
    endcase
    case (ext_size)
      SZ_BYTE: ext_data = {{24{ext_signed & lane8[7]}}, lane8};
      SZ_HALF: ext_data = {{16{ext_signed & lane16[15]}}, lane16};
      default: ext_data = ext_word;
    endcase
  end

  // Replace the addressed lane of the old word with the new store data.
  always_comb begin
    mrg_data = mrg_new;
    case (mrg_size)
      SZ_BYTE: begin
        case (mrg_off)
          2'd0:    mrg_data = {mrg_new[7:0], mrg_old[23:0]};
          2'd1:    mrg_data = {mrg_old[31:24], mrg_new[7:0], mrg_old[15:0]};
          2'd2:    mrg_data = {mrg_old[31:16], mrg_new[7:0], mrg_old[7:0]};
          2'd3:    mrg_data = {mrg_old[31:8], mrg_new[7:0]};
          default: mrg_data = mrg_old;
        endcase
      end
      SZ_HALF: begin
        if (mrg_off[1]) begin
          mrg_data = {mrg_old[31:16], mrg_new[15:0]};
        end else begin
          mrg_data = {mrg_new[15:0], mrg_old[15:0]};
        end
      end
      default: mrg_data = mrg_new;
    endcase
  end

endmodule

// File: rtl/lsu_rmw.sv
// lsu_rmw: load/store unit in front of a word-wide memory without byte enables.
// Sub-word stores are done as read (ACCESS) then merged write (WRITE).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid/req_ready        request handshake (ready only in IDLE)
//   req_load, req_size, req_signed, req_addr, req_wdata   request fields
//   resp_valid, resp_rdata, resp_err                      one-cycle response
//   mem_addr, mem_wdata, mem_we, mem_rdata                word memory port
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined     -> misaligned / reserved-size requests answer with resp_err
//   not defined -> low address bits are masked, reserved size acts as word
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_load,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  lsu_state_e        state, state_nxt;
  logic              load_q, signed_q, err_q;
  logic [1:0]        size_q, off_q;
  logic [31:0]       wdata_q, merge_q, rdata_q;
  logic [ADDR_W-3:0] addr_q;

  logic              accept, req_err;
  logic [1:0]        eff_size, eff_off;
  logic              sub_store;
  logic [31:0]       ext_data, mrg_data;

  assign accept    = req_valid && (state == IDLE);
  assign sub_store = !load_q && (size_q != SZ_WORD);

`ifdef LSU_MISALIGN_TRAP_EN
  // Flag misaligned halves/words and the reserved size.
  always_comb begin
    eff_size = req_size;
    eff_off  = req_addr[1:0];
    req_err  = 1'b0;
    case (req_size)
      SZ_HALF: req_err = req_addr[0];
      SZ_WORD: req_err = (req_addr[1:0] != 2'b00);
      SZ_RSVD: req_err = 1'b1;
      default: req_err = 1'b0;
    endcase
  end
`else
  // No trapping: reserved size becomes word, low offset bits are masked.
  always_comb begin
    eff_size = (req_size == SZ_RSVD) ? SZ_WORD : req_size;
    eff_off  = req_addr[1:0];
    req_err  = 1'b0;
    case (eff_size)
      SZ_HALF: eff_off = {req_addr[1], 1'b0};
      SZ_WORD: eff_off = 2'b00;
      default: eff_off = req_addr[1:0];
    endcase
  end
`endif

  lsu_lane_align u_align (
    .ext_word   (mem_rdata),
    .ext_off    (off_q),
    .ext_size   (size_q),
    .ext_signed (signed_q),
    .ext_data   (ext_data),
    .mrg_old    (merge_q),
    .mrg_new    (wdata_q),
    .mrg_off    (off_q),
    .mrg_size   (size_q),
    .mrg_data   (mrg_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = req_err ? RESP : ACCESS;
        end else begin
          state_nxt = IDLE;
        end
      end
      ACCESS:  state_nxt = sub_store ? WRITE : RESP;
      WRITE:   state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Request latches, merge capture and response data registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q   <= 1'b0;
      signed_q <= 1'b0;
      size_q   <= SZ_BYTE;
      off_q    <= 2'b00;
      wdata_q  <= 32'h0000_0000;
      addr_q   <= '0;
      merge_q  <= 32'h0000_0000;
      rdata_q  <= 32'h0000_0000;
      err_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            load_q   <= req_load;
            signed_q <= req_signed;
            size_q   <= eff_size;
            off_q    <= eff_off;
            wdata_q  <= req_wdata;
            addr_q   <= req_addr[ADDR_W-1:2];
            rdata_q  <= 32'h0000_0000;
            err_q    <= req_err;
          end
        end
        ACCESS: begin
          if (load_q) begin
            rdata_q <= ext_data;
          end else if (sub_store) begin
            merge_q <= mem_rdata;
          end
        end
        RESP: begin
          rdata_q <= 32'h0000_0000;
          err_q   <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  // All outputs come from registers only; mem_we is decoded from state so
  // an async reset removes it immediately.
  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = (state == WRITE) ? mrg_data : wdata_q;
  assign mem_we     = (state == WRITE) ||
                      ((state == ACCESS) && !load_q && (size_q == SZ_WORD));

endmodule

// File: tb/tb_lsu_rmw.sv
// tb_lsu_rmw: directed bench for lsu_rmw with a behavioural word memory
// (combinational read, write on rising edge when mem_we). Expected values are
// hand-computed from the big-endian lane rules.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_load = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [29:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [0:63];

  int checks = 0;
  int failures = 0;

  lsu_rmw #(.ADDR_W(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_load   (req_load),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[5:0]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[5:0]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Issue one request and observe cycles 1..6 after the accept edge.
  task automatic run_req(input logic ld, input logic [1:0] sz, input logic sg,
                         input logic [31:0] addr, input logic [31:0] wd,
                         output int resp_cyc, output logic [31:0] rdata,
                         output logic err, output logic [7:0] we_mask,
                         output logic [29:0] we_addr);
    resp_cyc = -1;
    rdata    = 32'hDEAD_BEEF;
    err      = 1'bx;
    we_mask  = 8'h00;
    we_addr  = 30'h0;
    @(negedge clk);
    req_load = ld; req_size = sz; req_signed = sg; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_we) begin
        we_mask[c] = 1'b1;
        we_addr    = mem_addr;
      end
      if (resp_valid && resp_cyc < 0) begin
        resp_cyc = c;
        rdata    = resp_rdata;
        err      = resp_err;
      end
      if (c < 6) begin
        @(posedge clk); #1;
      end
    end
  endtask

  int          rc;
  logic [31:0] rd;
  logic        er;
  logic [7:0]  wm;
  logic [29:0] wa;
  logic [7:0]  rdy_bits, vld_bits;
  logic [31:0] first_rd, second_rd;
  int          stray;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;

    // Reset state
    #3;
    check("rst_ready", {31'h0, req_ready}, 32'h1);
    check("rst_we", {31'h0, mem_we}, 32'h0);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'h0, resp_err}, 32'h0);
    check("rst_mem_addr", {2'b00, mem_addr}, 32'h0);
    check("rst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // sw 0xAABBCCDD -> 0x20
    run_req(1'b0, 2'b10, 1'b0, 32'h20, 32'hAABB_CCDD, rc, rd, er, wm, wa);
    check("sw_resp_cyc", rc, 32'd2);
    check("sw_we_mask", {24'h0, wm}, 32'h02);
    check("sw_we_addr", {2'b00, wa}, 32'h8);
    check("sw_mem", mem[8], 32'hAABB_CCDD);
    check("sw_rdata", rd, 32'h0);

    // lw 0x20
    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, rc, rd, er, wm, wa);
    check("lw_resp_cyc", rc, 32'd2);
    check("lw_rdata", rd, 32'hAABB_CCDD);
    check("lw_err", {31'h0, er}, 32'h0);
    check("lw_we_mask", {24'h0, wm}, 32'h0);

    // sb 0x11 -> 0x21 (upper wdata bits must be ignored)
    run_req(1'b0, 2'b00, 1'b0, 32'h21, 32'hFFFF_FF11, rc, rd, er, wm, wa);
    check("sb_resp_cyc", rc, 32'd3);
    check("sb_we_mask", {24'h0, wm}, 32'h04);
    check("sb_mem", mem[8], 32'hAA11_CCDD);

    // lb / lbu 0x23
    run_req(1'b1, 2'b00, 1'b1, 32'h23, 32'h0, rc, rd, er, wm, wa);
    check("lb_rdata", rd, 32'hFFFF_FFDD);
    run_req(1'b1, 2'b00, 1'b0, 32'h23, 32'h0, rc, rd, er, wm, wa);
    check("lbu_rdata", rd, 32'h0000_00DD);
    // lb 0x21: positive byte stays positive
    run_req(1'b1, 2'b00, 1'b1, 32'h21, 32'h0, rc, rd, er, wm, wa);
    check("lb_pos_rdata", rd, 32'h0000_0011);

    // sh 0x8001 -> 0x22
    run_req(1'b0, 2'b01, 1'b0, 32'h22, 32'h1234_8001, rc, rd, er, wm, wa);
    check("sh_resp_cyc", rc, 32'd3);
    check("sh_mem", mem[8], 32'hAA11_8001);
    run_req(1'b1, 2'b01, 1'b1, 32'h22, 32'h0, rc, rd, er, wm, wa);
    check("lh_rdata", rd, 32'hFFFF_8001);
    run_req(1'b1, 2'b01, 1'b0, 32'h20, 32'h0, rc, rd, er, wm, wa);
    check("lhu_rdata", rd, 32'h0000_AA11);

    // Misaligned lw 0x21
    run_req(1'b1, 2'b10, 1'b0, 32'h21, 32'h0, rc, rd, er, wm, wa);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_resp_cyc", rc, 32'd1);
    check("mis_err", {31'h0, er}, 32'h1);
    check("mis_rdata", rd, 32'h0);
`else
    check("mis_resp_cyc", rc, 32'd2);
    check("mis_err", {31'h0, er}, 32'h0);
    check("mis_rdata", rd, 32'hAA11_8001);
`endif
    check("mis_we_mask", {24'h0, wm}, 32'h0);

    // Back-to-back: valid held high; fields change while busy
    rdy_bits = 8'h00; vld_bits = 8'h00; first_rd = 32'h0; second_rd = 32'h0;
    @(negedge clk);
    req_load = 1'b1; req_size = 2'b10; req_signed = 1'b0; req_addr = 32'h20;
    req_valid = 1'b1;
    @(posedge clk); #1;
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) begin
        req_size = 2'b01; req_addr = 32'h22;
      end
      rdy_bits[c] = req_ready;
      vld_bits[c] = resp_valid;
      if (c == 2) first_rd = resp_rdata;
      if (c == 5) begin
        second_rd = resp_rdata;
        req_valid = 1'b0;
      end
      if (c < 5) begin
        @(posedge clk); #1;
      end
    end
    check("b2b_ready", {24'h0, rdy_bits}, 32'h08);
    check("b2b_resp", {24'h0, vld_bits}, 32'h24);
    check("b2b_first", first_rd, 32'hAA11_8001);
    check("b2b_second", second_rd, 32'h0000_8001);
    @(posedge clk); #1;

    // Reset during WRITE of a byte store
    @(negedge clk);
    req_load = 1'b0; req_size = 2'b00; req_addr = 32'h20; req_wdata = 32'h55;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("rstw_we_before", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rstw_we_drop", {31'h0, mem_we}, 32'h0);
    check("rstw_ready", {31'h0, req_ready}, 32'h1);
    @(posedge clk); #1;
    check("rstw_mem", mem[8], 32'hAA11_8001);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (resp_valid) stray++;
    end
    check("rstw_no_resp", stray, 32'd0);

    run_req(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, rc, rd, er, wm, wa);
    check("post_rst_lw", rd, 32'hAA11_8001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
